// File: rtl/apply_iteration_sync_pkg.sv
// ============================================================================
// Module   : apply_iteration_sync_pkg
// Brief    : Shared defaults and constant helpers for the iteration-end sync.
// Revision : 1.0
// ============================================================================
`default_nettype none

package apply_iteration_sync_pkg;

    localparam int DEF_V_ID_WIDTH = 32;
    localparam int DEF_CORE_NUM   = 32;
    localparam int DEF_ITER_WIDTH = 16;
    localparam int DEF_TREE_FANIN = 4;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // A single-input tree still gets one register level so latency never collapses to 0.
    function automatic int and_tree_depth(input int width, input int fanin);
        int n;
        int d;
        n = width;
        d = 0;
        while (n > 1) begin
            n = ceil_div(n, fanin);
            d = d + 1;
        end
        return (d < 1) ? 1 : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apply_iteration_sync_and_tree.sv
// ============================================================================
// Module   : pipelined_and_tree
// Brief    : Registered AND reduction with configurable fan-in, padding with 1s.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipelined_and_tree
    import apply_iteration_sync_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int FANIN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic             out
);

    localparam int DEPTH = and_tree_depth(WIDTH, FANIN);

    function automatic int level_width(input int lvl);
        int n;
        n = WIDTH;
        for (int i = 0; i < lvl; i++) begin
            n = ceil_div(n, FANIN);
        end
        return n;
    endfunction

    for (genvar l = 0; l < DEPTH; l++) begin : g_level
        localparam int IW = level_width(l);
        localparam int OW = level_width(l + 1);

        logic [IW-1:0] lin;
        logic [OW-1:0] nxt;
        logic [OW-1:0] q;

        if (l == 0) begin : g_src_in
            assign lin = in;
        end else begin : g_src_prev
            assign lin = g_level[l-1].q;
        end

        for (genvar j = 0; j < OW; j++) begin : g_node
            logic [FANIN-1:0] leaf;
            for (genvar k = 0; k < FANIN; k++) begin : g_leaf
                if (j * FANIN + k < IW) begin : g_real
                    assign leaf[k] = lin[j*FANIN+k];
                end else begin : g_pad
                    assign leaf[k] = 1'b1;
                end
            end
            assign nxt[j] = &leaf;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else begin
                q <= nxt;
            end
        end
    end

    assign out = g_level[DEPTH-1].q[0];

endmodule

`default_nettype wire

// File: rtl/apply_iteration_sync.sv
// ============================================================================
// Module   : apply_iteration_sync
// Brief    : Registers per-core vertex stream and broadcasts a global
//            iteration-end pulse once every core has reported.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apply_iteration_sync
    import apply_iteration_sync_pkg::*;
#(
    parameter int V_ID_WIDTH = DEF_V_ID_WIDTH,
    parameter int CORE_NUM   = DEF_CORE_NUM,
    parameter int TREE_FANIN = DEF_TREE_FANIN,
    parameter int ITER_WIDTH = DEF_ITER_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CORE_NUM*V_ID_WIDTH-1:0] front_active_v_id,
    input  logic [CORE_NUM-1:0]            front_active_v_updated,
    input  logic [CORE_NUM-1:0]            front_active_v_pull_first_flag,
    input  logic [CORE_NUM-1:0]            front_active_v_valid,
    input  logic [CORE_NUM-1:0]            front_iteration_end,
    input  logic [CORE_NUM-1:0]            front_iteration_end_valid,
    input  logic [ITER_WIDTH-1:0]          max_iter,
    output logic [CORE_NUM*V_ID_WIDTH-1:0] active_v_id,
    output logic [CORE_NUM-1:0]            active_v_updated,
    output logic [CORE_NUM-1:0]            active_v_pull_first_flag,
    output logic [CORE_NUM-1:0]            active_v_valid,
    output logic [CORE_NUM-1:0]            iteration_end,
    output logic [CORE_NUM-1:0]            iteration_end_valid,
    output logic [ITER_WIDTH-1:0]          iteration_count,
    output logic                           algorithm_done
);

    localparam int TREE_DEPTH = and_tree_depth(CORE_NUM, TREE_FANIN);
    localparam int FLUSH_W    = (TREE_DEPTH > 1) ? $clog2(TREE_DEPTH) : 1;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_COMMIT = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        RUN    = ST_RUN,
        COMMIT = ST_COMMIT,
        FLUSH  = ST_FLUSH,
        DONE   = ST_DONE
    } state_e;

    state_e                state;
    state_e                state_nxt;
    logic [FLUSH_W-1:0]    flush_cnt;
    logic [FLUSH_W-1:0]    flush_cnt_nxt;
    logic [ITER_WIDTH-1:0] count_nxt;
    logic [ITER_WIDTH-1:0] count_inc;
    logic                  done_nxt;
    logic [CORE_NUM-1:0]   end_seen;
    logic [CORE_NUM-1:0]   end_seen_nxt;
    logic                  tree_all;
    logic                  in_commit;

    for (genvar i = 0; i < CORE_NUM; i++) begin : g_core
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH] <= '0;
                active_v_updated[i]                     <= 1'b0;
                active_v_pull_first_flag[i]             <= 1'b0;
                active_v_valid[i]                       <= 1'b0;
            end else if (front_active_v_valid[i]) begin
                active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH] <= front_active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH];
                active_v_updated[i]                     <= front_active_v_updated[i];
                active_v_pull_first_flag[i]             <= front_active_v_pull_first_flag[i];
                active_v_valid[i]                       <= 1'b1;
            end else begin
                active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH] <= '0;
                active_v_updated[i]                     <= 1'b0;
                active_v_pull_first_flag[i]             <= 1'b0;
                active_v_valid[i]                       <= 1'b0;
            end
        end
    end

    assign in_commit = (state == COMMIT);

    // New reports OR in after the clear, so a report landing on COMMIT counts next round.
    assign end_seen_nxt = (in_commit ? '0 : end_seen)
                        | (front_iteration_end_valid & front_iteration_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            end_seen <= '0;
        end else begin
            end_seen <= end_seen_nxt;
        end
    end

    // Tree consumes the next-state flags so tree_all rises D cycles after the last report.
    pipelined_and_tree #(
        .WIDTH (CORE_NUM),
        .FANIN (TREE_FANIN)
    ) u_tree (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (end_seen_nxt),
        .out   (tree_all)
    );

    assign count_inc = iteration_count + ITER_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            flush_cnt       <= '0;
            iteration_count <= '0;
            algorithm_done  <= 1'b0;
        end else begin
            state           <= state_nxt;
            flush_cnt       <= flush_cnt_nxt;
            iteration_count <= count_nxt;
            algorithm_done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        count_nxt     = iteration_count;
        done_nxt      = algorithm_done;
        case (state)
            RUN: begin
                if (tree_all) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                count_nxt = count_inc;
                if ((max_iter != '0) && (count_inc == max_iter)) begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    flush_cnt_nxt = FLUSH_W'(TREE_DEPTH - 1);
                    state_nxt     = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    flush_cnt_nxt = flush_cnt - FLUSH_W'(1);
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign iteration_end       = {CORE_NUM{in_commit}};
    assign iteration_end_valid = {CORE_NUM{in_commit}};

endmodule

`default_nettype wire

// File: tb/tb_apply_iteration_sync.sv
// ============================================================================
// Module   : tb_apply_iteration_sync
// Brief    : Directed bench for a 32-core/fan-in-4 and a 5-core/fan-in-2 build.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apply_iteration_sync;

    localparam int V = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- 32-core instance ----------------
    logic          a_rst_n = 1'b0;
    logic [255:0]  a_vid = '0;
    logic [31:0]   a_upd = '0, a_pf = '0, a_vv = '0, a_end = '0, a_endv = '0;
    logic [15:0]   a_max = '0;
    logic [255:0]  a_av_id;
    logic [31:0]   a_av_upd, a_av_pf, a_av_v, a_ie, a_iev;
    logic [15:0]   a_cnt;
    logic          a_done;

    apply_iteration_sync #(.V_ID_WIDTH(V), .CORE_NUM(32), .TREE_FANIN(4), .ITER_WIDTH(16)) u_a (
        .clk                            (clk),
        .rst_n                          (a_rst_n),
        .front_active_v_id              (a_vid),
        .front_active_v_updated         (a_upd),
        .front_active_v_pull_first_flag (a_pf),
        .front_active_v_valid           (a_vv),
        .front_iteration_end            (a_end),
        .front_iteration_end_valid      (a_endv),
        .max_iter                       (a_max),
        .active_v_id                    (a_av_id),
        .active_v_updated               (a_av_upd),
        .active_v_pull_first_flag       (a_av_pf),
        .active_v_valid                 (a_av_v),
        .iteration_end                  (a_ie),
        .iteration_end_valid            (a_iev),
        .iteration_count                (a_cnt),
        .algorithm_done                 (a_done)
    );

    // ---------------- 5-core instance ----------------
    logic          b_rst_n = 1'b0;
    logic [39:0]   b_vid = '0;
    logic [4:0]    b_upd = '0, b_pf = '0, b_vv = '0, b_end = '0, b_endv = '0;
    logic [15:0]   b_max = '0;
    logic [39:0]   b_av_id;
    logic [4:0]    b_av_upd, b_av_pf, b_av_v, b_ie, b_iev;
    logic [15:0]   b_cnt;
    logic          b_done;

    apply_iteration_sync #(.V_ID_WIDTH(V), .CORE_NUM(5), .TREE_FANIN(2), .ITER_WIDTH(16)) u_b (
        .clk                            (clk),
        .rst_n                          (b_rst_n),
        .front_active_v_id              (b_vid),
        .front_active_v_updated         (b_upd),
        .front_active_v_pull_first_flag (b_pf),
        .front_active_v_valid           (b_vv),
        .front_iteration_end            (b_end),
        .front_iteration_end_valid      (b_endv),
        .max_iter                       (b_max),
        .active_v_id                    (b_av_id),
        .active_v_updated               (b_av_upd),
        .active_v_pull_first_flag       (b_av_pf),
        .active_v_valid                 (b_av_v),
        .iteration_end                  (b_ie),
        .iteration_end_valid            (b_iev),
        .iteration_count                (b_cnt),
        .algorithm_done                 (b_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vertex vectors for the 5-core build: inputs, and outputs one cycle later.
    logic [39:0] in_id  [4] = '{40'h0102030405, 40'hFFFFFFFFFF, 40'hA1A2A3A4A5, 40'h1234567890};
    logic [4:0]  in_upd [4] = '{5'h13, 5'h1F, 5'h1F, 5'h1F};
    logic [4:0]  in_pf  [4] = '{5'h0A, 5'h1F, 5'h03, 5'h1F};
    logic [4:0]  in_v   [4] = '{5'h1F, 5'h00, 5'h15, 5'h00};
    logic [39:0] ex_id  [4] = '{40'h0102030405, 40'h0, 40'hA100A300A5, 40'h0};
    logic [4:0]  ex_upd [4] = '{5'h13, 5'h00, 5'h15, 5'h00};
    logic [4:0]  ex_pf  [4] = '{5'h0A, 5'h00, 5'h01, 5'h00};
    logic [4:0]  ex_v   [4] = '{5'h1F, 5'h00, 5'h15, 5'h00};

    initial begin
        logic exp_pulse;
        repeat (3) @(posedge clk);
        #1;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        for (int n = 0; n <= 120; n++) begin
            if (n == 86) begin
                a_rst_n = 1'b1;
                a_max   = 16'd2;
            end
            a_end = '0; a_endv = '0; a_vv = '0; a_vid = '0;
            case (n)
                10:  begin a_end = 32'h7FFFFFFF; a_endv = 32'h7FFFFFFF; end
                20:  begin a_end = 32'h80000000; a_endv = 32'h80000000; end
                32, 34, 36: begin a_end = 32'h00000020; a_endv = 32'h00000020; end
                33:  begin a_end = 32'h00000000; a_endv = 32'h00000040; end
                35:  begin a_end = 32'hFFFFFFBF; a_endv = 32'hFFFFFFBF; end
                45:  begin a_end = 32'h00000040; a_endv = 32'h00000040; end
                60, 80, 90, 100, 110: begin a_end = '1; a_endv = '1; end
                64:  begin a_end = 32'h00000008; a_endv = 32'h00000008; end
                70:  begin a_end = 32'hFFFFFFF7; a_endv = 32'hFFFFFFF7; end
                82:  begin a_vv = 32'h1; a_vid[7:0] = 8'h5A; end
                default: ;
            endcase

            exp_pulse = (n == 24) || (n == 49) || (n == 64) || (n == 74) || (n == 94) || (n == 104);
            check("a_pulse_valid", a_iev, exp_pulse ? 64'hFFFFFFFF : 64'h0);
            check("a_pulse_end", a_ie, exp_pulse ? 64'hFFFFFFFF : 64'h0);

            if (n == 0) begin
                check("a_rst_count", a_cnt, 0);
                check("a_rst_done", a_done, 0);
                check("a_rst_vvalid", a_av_v, 0);
                check("a_rst_vid", a_av_id[63:0], 0);
                check("b_rst_count", b_cnt, 0);
                check("b_rst_vvalid", b_av_v, 0);
            end
            if (n == 50) check("a_count_after_dup", a_cnt, 2);
            if (n == 65) begin
                check("a_end_seen_commit_report", u_a.end_seen, 64'h8);
                check("a_count_3", a_cnt, 3);
            end
            if (n == 75) check("a_count_4", a_cnt, 4);
            if (n == 83) begin
                check("a_tree_all_pre_reset", u_a.tree_all, 1);
                check("a_vid_core0", a_av_id[7:0], 8'h5A);
                check("a_vvalid_core0", a_av_v, 1);
                #3;
                a_rst_n = 1'b0;
                #1;
                check("a_async_rst_count", a_cnt, 0);
                check("a_async_rst_vvalid", a_av_v, 0);
                check("a_async_rst_vid", a_av_id[63:0], 0);
                check("a_async_rst_pulse", a_iev, 0);
                check("a_async_rst_end_seen", u_a.end_seen, 0);
            end
            if (n == 87) check("a_end_seen_after_rst", u_a.end_seen, 0);
            if (n == 95) check("a_limit_count_1", a_cnt, 1);
            if (n == 104) check("a_done_before_limit", a_done, 0);
            if (n == 120) begin
                check("a_done_at_limit", a_done, 1);
                check("a_count_at_limit", a_cnt, 2);
                check("a_end_seen_in_done", u_a.end_seen, 64'hFFFFFFFF);
            end
            tick();
        end

        a_end = '0; a_endv = '0;
        for (int m = 0; m < 14; m++) begin
            b_vid = '0; b_upd = '0; b_pf = '0; b_vv = '0; b_end = '0; b_endv = '0;
            if (m < 4) begin
                b_vid = in_id[m];
                b_upd = in_upd[m];
                b_pf  = in_pf[m];
                b_vv  = in_v[m];
            end
            if (m == 5) begin b_end = 5'h0F; b_endv = 5'h0F; end
            if (m == 6) begin b_end = 5'h10; b_endv = 5'h10; end
            if (m >= 1 && m <= 4) begin
                check("b_vid", b_av_id, ex_id[m-1]);
                check("b_vupd", b_av_upd, ex_upd[m-1]);
                check("b_vpf", b_av_pf, ex_pf[m-1]);
                check("b_vvalid", b_av_v, ex_v[m-1]);
            end
            check("b_pulse_valid", b_iev, (m == 10) ? 64'h1F : 64'h0);
            check("b_pulse_end", b_ie, (m == 10) ? 64'h1F : 64'h0);
            if (m == 11) check("b_count", b_cnt, 1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
